// File: rtl/fifo_sync_prog.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds,
// sticky overflow/underflow error and a registered read port.
//
// Ports:
//   clk, reset (sync, active-high)
//   push, data_in           write side
//   pop, data_out, data_valid  read side, 1-cycle latency
//   af_thresh, ae_thresh    live threshold inputs (count units)
//   fill_level, full, empty, almost_full, almost_empty  registered-count status
//   err_clr, error          sticky error with clear
//   peak_level              only when FIFO_PEAK_EN is defined
//
// Optional feature macro: FIFO_PEAK_EN (adds peak_level tracking).
module fifo_sync_prog #(
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic [ADDR_WIDTH:0]   ae_thresh,
    output logic [ADDR_WIDTH:0]   fill_level,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    input  logic                  err_clr,
`ifdef FIFO_PEAK_EN
    output logic [ADDR_WIDTH:0]   peak_level,
`endif
    output logic                  error
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  data_valid_q, data_valid_d;
    logic                  error_q, error_d;

    logic pop_ok;
    logic push_ok;
    logic overflow;
    logic underflow;

    // Status comes from the registered count only.
    assign empty        = (count_q == '0);
    assign full         = (count_q == DEPTH_C);
    assign almost_full  = (count_q >= af_thresh);
    assign almost_empty = (count_q <= ae_thresh);
    assign fill_level   = count_q;
    assign data_out     = data_out_q;
    assign data_valid   = data_valid_q;
    assign error        = error_q;

    // A push at full is admitted only when a real pop frees a slot;
    // a pop at empty is never admitted, even alongside a push.
    assign pop_ok    = pop & ~empty;
    assign push_ok   = push & (~full | pop_ok);
    assign overflow  = push & ~push_ok;
    assign underflow = pop & empty;

    always_comb begin
        count_d      = count_q
                     + (ADDR_WIDTH+1)'(push_ok)
                     - (ADDR_WIDTH+1)'(pop_ok);
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        error_d      = error_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d     = rd_ptr_q + 1'b1;
            data_out_d   = mem_q[rd_ptr_q];
            data_valid_d = 1'b1;
        end

        // A fresh error outranks a same-cycle clear.
        if (overflow | underflow) begin
            error_d = 1'b1;
        end else if (err_clr) begin
            error_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            error_q      <= error_d;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push_ok && !reset) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

`ifdef FIFO_PEAK_EN
    logic [ADDR_WIDTH:0] peak_q, peak_d;

    always_comb begin
        peak_d = peak_q;
        if (err_clr) begin
            peak_d = count_d;
        end else if (count_d > peak_q) begin
            peak_d = count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak_level = peak_q;
`endif

endmodule
